// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the forwarding/hazard controller: regfile select code,
// MULT/DIV FSM encoding and the select-width helper.
package fwd_hazard_unit_pkg;

  localparam int SEL_REGFILE = 0;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  function automatic int sel_width(input int num_fwd);
    return $clog2(num_fwd + 1);
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_fwd_src_match.sv
// Youngest-first producer match for one ID-stage source operand.
// Combinational: sel = winning stage + 1 (0 = regfile), hazard = winner not ready.
module fwd_src_match
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 3,
  parameter int SEL_W   = 2
) (
  input  logic [REG_AW-1:0]         src_i,
  input  logic                      used_i,
  input  logic [NUM_FWD*REG_AW-1:0] stg_wr_addr_i,
  input  logic [NUM_FWD-1:0]        stg_wr_en_i,
  input  logic [NUM_FWD-1:0]        stg_wr_ready_i,
  output logic [SEL_W-1:0]          sel_o,
  output logic                      hazard_o
);

  // Walk oldest to youngest so the youngest match is the last one written.
  always_comb begin
    sel_o    = SEL_W'(SEL_REGFILE);
    hazard_o = 1'b0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (used_i && stg_wr_en_i[k] &&
          (stg_wr_addr_i[k*REG_AW +: REG_AW] != '0) &&
          (stg_wr_addr_i[k*REG_AW +: REG_AW] == src_i)) begin
        sel_o    = SEL_W'(k + 1);
        hazard_o = !stg_wr_ready_i[k];
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select, load-use / MULT-DIV stall generation and stall counter.
// Selects and stalls are combinational; MD busy tracking and stall_cnt are registered.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 3,
  parameter int MD_LAT  = 4,
  parameter int CNT_W   = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]                 id_src,
  input  logic [NUM_SRC-1:0]                        id_src_used,
  input  logic                                      id_is_md,
  input  logic                                      id_reads_hilo,
  input  logic [NUM_FWD*REG_AW-1:0]                 stg_wr_addr,
  input  logic [NUM_FWD-1:0]                        stg_wr_en,
  input  logic [NUM_FWD-1:0]                        stg_wr_ready,
  output logic [NUM_SRC*sel_width(NUM_FWD)-1:0]     fwd_sel,
  output logic                                      stall,
  output logic                                      bubble_ex,
  output logic                                      md_busy,
  output logic                                      md_start,
  output logic [CNT_W-1:0]                          stall_cnt
);

  localparam int SEL_W = sel_width(NUM_FWD);
  localparam int MDC_W = $clog2(MD_LAT + 1);
  // The issue cycle itself counts toward the latency, so the unit frees up one
  // count early; a single-cycle unit still spends one cycle in BUSY.
  localparam int MD_DONE = (MD_LAT > 1) ? 2 : 1;

  logic [NUM_SRC*SEL_W-1:0] sel_raw;
  logic [NUM_SRC-1:0]       src_haz;
  logic                     load_use;
  logic                     md_haz;
  md_state_e                state_q, state_d;
  logic [MDC_W-1:0]         md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0]         stall_cnt_q, stall_cnt_d;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_match #(
      .REG_AW  (REG_AW),
      .NUM_FWD (NUM_FWD),
      .SEL_W   (SEL_W)
    ) u_match (
      .src_i          (id_src[i*REG_AW +: REG_AW]),
      .used_i         (id_src_used[i]),
      .stg_wr_addr_i  (stg_wr_addr),
      .stg_wr_en_i    (stg_wr_en),
      .stg_wr_ready_i (stg_wr_ready),
      .sel_o          (sel_raw[i*SEL_W +: SEL_W]),
      .hazard_o       (src_haz[i])
    );
  end

  assign load_use  = |src_haz;
  assign md_haz    = id_valid && (id_is_md || id_reads_hilo) && md_busy;
  assign stall     = !rst && id_valid && (load_use || md_haz);
  assign bubble_ex = stall;
  assign md_start  = !rst && id_valid && id_is_md && !stall;
  assign fwd_sel   = rst ? '0 : sel_raw;
  assign stall_cnt = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MD_IDLE;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (md_start) begin
          state_d  = MD_BUSY;
          md_cnt_d = MDC_W'(MD_LAT);
        end
      end
      MD_BUSY: begin
        md_cnt_d = md_cnt_q - 1'b1;
        if (int'(md_cnt_q) <= MD_DONE) begin
          state_d  = MD_IDLE;
          md_cnt_d = '0;
        end
      end
      default: begin
        state_d  = MD_IDLE;
        md_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    md_busy = !rst && (state_q == MD_BUSY);
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed and random checks of fwd_hazard_unit against a cycle-level reference model.
module tb_fwd_hazard_unit;

  localparam int REG_AW  = 5;
  localparam int NUM_SRC = 2;
  localparam int NUM_FWD = 3;
  localparam int MD_LAT  = 4;
  localparam int CNT_W   = 5;
  localparam int SEL_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int MD_BUSY_CYC = (MD_LAT > 1) ? MD_LAT - 1 : 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst;
  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [NUM_SRC-1:0]        id_src_used;
  logic                      id_is_md;
  logic                      id_reads_hilo;
  logic [NUM_FWD*REG_AW-1:0] stg_wr_addr;
  logic [NUM_FWD-1:0]        stg_wr_en;
  logic [NUM_FWD-1:0]        stg_wr_ready;
  logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
  logic                      stall;
  logic                      bubble_ex;
  logic                      md_busy;
  logic                      md_start;
  logic [CNT_W-1:0]          stall_cnt;

  fwd_hazard_unit #(
    .REG_AW  (REG_AW),
    .NUM_SRC (NUM_SRC),
    .NUM_FWD (NUM_FWD),
    .MD_LAT  (MD_LAT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_src        (id_src),
    .id_src_used   (id_src_used),
    .id_is_md      (id_is_md),
    .id_reads_hilo (id_reads_hilo),
    .stg_wr_addr   (stg_wr_addr),
    .stg_wr_en     (stg_wr_en),
    .stg_wr_ready  (stg_wr_ready),
    .fwd_sel       (fwd_sel),
    .stall         (stall),
    .bubble_ex     (bubble_ex),
    .md_busy       (md_busy),
    .md_start      (md_start),
    .stall_cnt     (stall_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: cycle number, MULT/DIV busy window, stall count.
  int cyc      = 0;
  int issue_c  = -100;
  int busy_end = -100;
  int m_cnt    = 0;

  logic [NUM_SRC*SEL_W-1:0] o_fwd;
  logic                     o_stall, o_bub, o_busy, o_start;
  logic [CNT_W-1:0]         o_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_stage(input int k, input logic [REG_AW-1:0] a, input logic en, input logic rdy);
    stg_wr_addr[k*REG_AW +: REG_AW] = a;
    stg_wr_en[k]    = en;
    stg_wr_ready[k] = rdy;
  endtask

  task automatic set_src(input int i, input logic [REG_AW-1:0] a, input logic used);
    id_src[i*REG_AW +: REG_AW] = a;
    id_src_used[i] = used;
  endtask

  task automatic clear_inputs();
    id_valid      = 1'b0;
    id_src        = '0;
    id_src_used   = '0;
    id_is_md      = 1'b0;
    id_reads_hilo = 1'b0;
    stg_wr_addr   = '0;
    stg_wr_en     = '0;
    stg_wr_ready  = '1;
  endtask

  // One cycle: compare every output against the model mid-cycle, then advance the model.
  task automatic step(input string tag);
    int                       sel;
    logic                     lu, busy, e_stall, e_start;
    logic [NUM_SRC*SEL_W-1:0] e_fwd;
    logic [REG_AW-1:0]        a, s;
    @(negedge clk);
    lu    = 1'b0;
    e_fwd = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      s   = id_src[i*REG_AW +: REG_AW];
      sel = 0;
      for (int k = 0; k < NUM_FWD; k++) begin
        a = stg_wr_addr[k*REG_AW +: REG_AW];
        if (sel == 0 && id_src_used[i] && stg_wr_en[k] && a != 0 && a == s) sel = k + 1;
      end
      if (sel != 0 && !stg_wr_ready[sel-1]) lu = 1'b1;
      if (!rst) e_fwd[i*SEL_W +: SEL_W] = SEL_W'(sel);
    end
    busy    = !rst && (cyc > issue_c) && (cyc <= busy_end);
    e_stall = !rst && id_valid && (lu || ((id_is_md || id_reads_hilo) && busy));
    e_start = !rst && id_valid && id_is_md && !e_stall;

    o_fwd = fwd_sel; o_stall = stall; o_bub = bubble_ex;
    o_busy = md_busy; o_start = md_start; o_cnt = stall_cnt;
    chk({tag, "/fwd_sel"},   32'(o_fwd),   32'(e_fwd));
    chk({tag, "/stall"},     32'(o_stall), 32'(e_stall));
    chk({tag, "/bubble_ex"}, 32'(o_bub),   32'(e_stall));
    chk({tag, "/md_busy"},   32'(o_busy),  32'(busy));
    chk({tag, "/md_start"},  32'(o_start), 32'(e_start));
    chk({tag, "/stall_cnt"}, 32'(o_cnt),   32'(m_cnt));

    @(posedge clk);
    if (rst) begin
      m_cnt    = 0;
      issue_c  = -100;
      busy_end = -100;
    end else begin
      if (e_stall && m_cnt < CNT_MAX) m_cnt++;
      if (e_start) begin
        issue_c  = cyc;
        busy_end = cyc + MD_BUSY_CYC;
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    logic [CNT_W-1:0] cnt_before;
    rst = 1'b1;
    clear_inputs();
    step("reset");
    chk("reset_fwd_sel", 32'(o_fwd), 32'd0);
    chk("reset_stall", 32'(o_stall), 32'd0);
    rst = 1'b0;
    step("post_reset");

    // EX and WB both write r8: youngest (EX) wins.
    id_valid = 1'b1;
    set_stage(0, 5'd8, 1'b1, 1'b1);
    set_stage(2, 5'd8, 1'b1, 1'b1);
    set_src(0, 5'd8, 1'b1);
    step("t1");
    chk("t1_sel0", 32'(o_fwd[SEL_W-1:0]), 32'd1);
    chk("t1_stall", 32'(o_stall), 32'd0);

    // Unready EX load to r9 is not hidden by a ready ME write of r9.
    clear_inputs();
    id_valid = 1'b1;
    set_stage(0, 5'd9, 1'b1, 1'b0);
    set_stage(1, 5'd9, 1'b1, 1'b1);
    set_src(1, 5'd9, 1'b1);
    step("t2");
    cnt_before = o_cnt;
    chk("t2_stall", 32'(o_stall), 32'd1);
    chk("t2_bubble", 32'(o_bub), 32'd1);
    chk("t2_sel1", 32'(o_fwd[SEL_W +: SEL_W]), 32'd1);
    clear_inputs();
    step("t2_after");
    chk("t2_cnt_inc", 32'(o_cnt), 32'(cnt_before) + 32'd1);

    // ME load to r5, EX writes r6; then the same with src0 unused.
    id_valid = 1'b1;
    set_stage(1, 5'd5, 1'b1, 1'b0);
    set_stage(0, 5'd6, 1'b1, 1'b1);
    set_src(0, 5'd5, 1'b1);
    step("t3a");
    chk("t3a_stall", 32'(o_stall), 32'd1);
    chk("t3a_sel0", 32'(o_fwd[SEL_W-1:0]), 32'd2);
    id_src_used[0] = 1'b0;
    step("t3b");
    chk("t3b_stall", 32'(o_stall), 32'd0);
    chk("t3b_sel0", 32'(o_fwd[SEL_W-1:0]), 32'd0);

    // All stages write r0 (even unready): never forwarded, never stalls.
    for (int k = 0; k < NUM_FWD; k++) set_stage(k, 5'd0, 1'b1, 1'b0);
    set_src(0, 5'd0, 1'b1);
    step("t4");
    chk("t4_sel0", 32'(o_fwd[SEL_W-1:0]), 32'd0);
    chk("t4_stall", 32'(o_stall), 32'd0);

    // MULT at t, MFLO from t+1: stalled t+1..t+3, accepted at t+4.
    clear_inputs();
    id_valid = 1'b1;
    id_is_md = 1'b1;
    step("t5_issue");
    chk("t5_start", 32'(o_start), 32'd1);
    id_is_md = 1'b0;
    id_reads_hilo = 1'b1;
    for (int n = 1; n < MD_LAT; n++) begin
      step("t5_wait");
      chk("t5_wait_stall", 32'(o_stall), 32'd1);
      chk("t5_wait_busy", 32'(o_busy), 32'd1);
    end
    step("t5_accept");
    chk("t5_accept_stall", 32'(o_stall), 32'd0);
    chk("t5_accept_busy", 32'(o_busy), 32'd0);

    // Reset while BUSY with two cycles of count left.
    clear_inputs();
    id_valid = 1'b1;
    id_is_md = 1'b1;
    step("t6_issue");
    clear_inputs();
    step("t6_b1");
    step("t6_b2");
    rst = 1'b1;
    step("t6_rst");
    chk("t6_rst_busy", 32'(o_busy), 32'd0);
    rst = 1'b0;
    id_valid = 1'b1;
    id_reads_hilo = 1'b1;
    step("t6_mflo");
    chk("t6_busy", 32'(o_busy), 32'd0);
    chk("t6_cnt", 32'(o_cnt), 32'd0);
    chk("t6_stall", 32'(o_stall), 32'd0);

    // Hold a load-use stall well past counter saturation.
    clear_inputs();
    id_valid = 1'b1;
    set_stage(0, 5'd7, 1'b1, 1'b0);
    set_src(0, 5'd7, 1'b1);
    for (int n = 0; n < CNT_MAX + 8; n++) step("sat");
    chk("sat_cnt", 32'(o_cnt), 32'(CNT_MAX));

    // Random traffic over a small register set to provoke overlapping matches.
    for (int n = 0; n < 600; n++) begin
      rst           = ($urandom_range(0, 59) == 0);
      id_valid      = ($urandom_range(0, 4) != 0);
      id_is_md      = ($urandom_range(0, 7) == 0);
      id_reads_hilo = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NUM_SRC; i++)
        set_src(i, REG_AW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      for (int k = 0; k < NUM_FWD; k++)
        set_stage(k, REG_AW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0));
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
